uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver feeding a first-word-fall-through receive FIFO
// Define UART_RX_PARITY_EN to receive and check one even-parity bit per frame.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       CLK100MHZ,
  input  logic       RESET,
  input  logic       uart_rxd,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       err_clr,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       irq
);

  localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_L = CW'(HALF);
  localparam logic [AW:0]   FULL_L = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            push_q, push_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            frame_err_q, frame_err_d, overrun_q, overrun_d, irq_q, irq_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic            rx, expired, frame_set, pop, full, do_push;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_q, par_bad_d, parity_err_q, parity_err_d, par_set;
`endif

  assign rx      = sync2_q;
  assign expired = (cnt_q == '0);

  always_comb begin
    sync1_d   = uart_rxd;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    par_set   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        bit_idx_d = '0;
        if (!rx) begin
          state_d = S_START;
          cnt_d   = HALF_L;
        end
      end
      S_START: begin
        if (expired) begin
          // A line that is high again at mid start bit was only a glitch.
          state_d = rx ? S_IDLE : S_DATA;
          cnt_d   = DIV_M1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (expired) begin
          shift_d = {rx, shift_q[7:1]};
          cnt_d   = DIV_M1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (expired) begin
          par_bad_d = rx ^ (^shift_q);
          cnt_d     = DIV_M1;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
`else
        state_d = S_STOP;
`endif
      end
      S_STOP: begin
        if (expired) begin
`ifdef UART_RX_PARITY_EN
          par_set = par_bad_q;
          push_d  = rx && !par_bad_q;
`else
          push_d  = rx;
`endif
          if (rx) begin
            state_d = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (rx) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  always_comb begin
    pop      = rd_en && (count_q != '0);
    full     = (count_q == FULL_L);
    do_push  = push_q && (!full || pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !pop) count_d = count_q + (AW + 1)'(1);
    if (pop && !do_push) count_d = count_q - (AW + 1)'(1);
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = shift_q;
    frame_err_d = frame_set ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
    overrun_d   = (push_q && full && !pop) ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
`ifdef UART_RX_PARITY_EN
    parity_err_d = par_set ? 1'b1 : (err_clr ? 1'b0 : parity_err_q);
`endif
    irq_d = rd_valid | frame_err_q | overrun_q | parity_err;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      irq_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      irq_q       <= irq_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    mem_q <= mem_d;
  end

  assign rd_valid  = (count_q != '0);
  assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign irq       = irq_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue model
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx_fifo;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 62500;
  localparam int DEPTH  = 16;
  localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF   = DIV / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int NBITS  = 11;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int NBITS  = 10;
`endif
  // Cycles from the start-bit falling edge to the FIFO push cycle.
  localparam int PUSH_AT = 3 + HALF + (NBITS - 1) * DIV + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, frame_err, overrun, parity_err, irq;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] model_q[$];
  logic       exp_ovr = 1'b0;
  logic       exp_par = 1'b0;

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .CLK100MHZ(clk), .RESET(rst), .uart_rxd(rxd), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .err_clr(err_clr), .frame_err(frame_err), .overrun(overrun),
    .parity_err(parity_err), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line is left low after a low stop bit so callers can hold a break.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    @(posedge clk);
    #1 rxd = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(DIV);
    end
    if (PAR_EN) begin
      rxd = par;
      tick(DIV);
    end
    rxd = stop;
    tick(DIV);
  endtask

  task automatic good_byte(input logic [7:0] b);
    send_frame(b, ^b, 1'b1);
    tick(2);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rxd = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    model_q.delete();
    exp_ovr = 1'b0;
    exp_par = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    n_checks++; if ({frame_err, overrun, parity_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {frame_err, overrun, parity_err}); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
  endtask

  task automatic test_single();
    good_byte(8'hA5);
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got v=%b d=%h want v=1 d=a5", rd_valid, rd_data); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL single_irq: got %b want 1", irq); end
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
    void'(model_q.pop_front());
    n_checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin n_fail++; $display("FAIL single_pop: got v=%b d=%h want v=0 d=00", rd_valid, rd_data); end
    tick(2);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_glitch();
    @(posedge clk);
    #1 rxd = 1'b0;
    tick(HALF / 2);
    rxd = 1'b1;
    tick(3 * DIV);
    n_checks++; if ({rd_valid, frame_err, overrun, parity_err} !== 4'b0000) begin n_fail++; $display("FAIL glitch_quiet: got %b want 0000", {rd_valid, frame_err, overrun, parity_err}); end
    good_byte(8'h5A);
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin n_fail++; $display("FAIL glitch_recover: got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, model_q[0]); end
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
    void'(model_q.pop_front());
  endtask

  task automatic test_frame_err();
    int hi;
    send_frame(8'h3C, ^8'h3C, 1'b0);
    tick(2 * DIV);
    n_checks++; if (frame_err !== 1'b1 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL frame_set: got fe=%b v=%b want fe=1 v=0", frame_err, rd_valid); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL frame_irq: got %b want 1", irq); end
    rxd = 1'b1;
    tick(DIV);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL frame_sticky: got %b want 1", frame_err); end
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL frame_clear: got %b want 0", frame_err); end
    // With err_clr held high the set must still show for exactly one cycle.
    hi = 0;
    err_clr = 1'b1;
    fork
      send_frame(8'h3C, ^8'h3C, 1'b0);
      repeat (NBITS * DIV + 8) begin
        @(posedge clk); #1;
        if (frame_err === 1'b1) hi++;
      end
    join
    err_clr = 1'b0;
    rxd = 1'b1;
    tick(DIV);
    n_checks++; if (hi !== 1) begin n_fail++; $display("FAIL frame_set_wins: got %0d cycles high want 1", hi); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL frame_dropped: got v=%b want 0", rd_valid); end
  endtask

  task automatic test_overrun();
    for (int i = 0; i <= 16; i++) good_byte(8'(i));
    n_checks++; if (overrun !== exp_ovr) begin n_fail++; $display("FAIL ovr_set: got %b want %b", overrun, exp_ovr); end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin n_fail++; $display("FAIL ovr_order[%0d]: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, model_q[0]); end
      rd_en = 1'b1; tick(1); rd_en = 1'b0;
      void'(model_q.pop_front());
    end
    n_checks++; if (rd_valid !== 1'b0 || overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_drained: got v=%b ovr=%b want v=0 ovr=1", rd_valid, overrun); end
    err_clr = 1'b1; rd_en = 1'b1; tick(1); err_clr = 1'b0; rd_en = 1'b0;
    exp_ovr = 1'b0;
    n_checks++; if (overrun !== 1'b0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_clear_empty_pop: got ovr=%b v=%b want 0 0", overrun, rd_valid); end
    good_byte(8'hC3);
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin n_fail++; $display("FAIL empty_pop_ignored: got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, model_q[0]); end
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
    void'(model_q.pop_front());
  endtask

  task automatic test_push_pop_full();
    for (int i = 0; i < DEPTH; i++) good_byte(8'(8'h40 + i));
    fork
      send_frame(8'h99, ^8'h99, 1'b1);
      begin
        @(posedge clk); #1;
        tick(PUSH_AT);
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin n_fail++; $display("FAIL full_head: got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, model_q[0]); end
        rd_en = 1'b1; tick(1); rd_en = 1'b0;
        void'(model_q.pop_front());
      end
    join
    model_q.push_back(8'h99);
    tick(2);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL full_no_overrun: got %b want 0", overrun); end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin n_fail++; $display("FAIL full_order[%0d]: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, model_q[0]); end
      rd_en = 1'b1; tick(1); rd_en = 1'b0;
      void'(model_q.pop_front());
    end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL full_count16: got v=%b want 0 after 16 pops", rd_valid); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       bad;
    int         npop;
    for (int it = 0; it < 12; it++) begin
      b   = 8'($urandom);
      bad = PAR_EN && ($urandom_range(0, 3) == 0);
      send_frame(b, (^b) ^ bad, 1'b1);
      tick(2);
      if (bad) exp_par = 1'b1;
      else if (model_q.size() < DEPTH) model_q.push_back(b);
      else exp_ovr = 1'b1;
      n_checks++; if (parity_err !== exp_par || overrun !== exp_ovr) begin n_fail++; $display("FAIL rand_flags[%0d]: got par=%b ovr=%b want par=%b ovr=%b", it, parity_err, overrun, exp_par, exp_ovr); end
      npop = $urandom_range(0, model_q.size());
      for (int k = 0; k < npop; k++) begin
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin n_fail++; $display("FAIL rand_pop[%0d]: got v=%b d=%h want v=1 d=%h", it, rd_valid, rd_data, model_q[0]); end
        rd_en = 1'b1; tick(1); rd_en = 1'b0;
        void'(model_q.pop_front());
      end
      tick($urandom_range(1, DIV));
    end
    while (model_q.size() > 0) begin
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin n_fail++; $display("FAIL rand_drain: got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, model_q[0]); end
      rd_en = 1'b1; tick(1); rd_en = 1'b0;
      void'(model_q.pop_front());
    end
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    exp_par = 1'b0;
  endtask

  task automatic test_reset_midframe();
    @(posedge clk);
    #1 rxd = 1'b0;
    tick(4 * DIV);
    do_reset();
    tick(2 * DIV);
    n_checks++; if ({rd_valid, frame_err, overrun, parity_err} !== 4'b0000) begin n_fail++; $display("FAIL midreset_quiet: got %b want 0000", {rd_valid, frame_err, overrun, parity_err}); end
    good_byte(8'h81);
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin n_fail++; $display("FAIL midreset_rx: got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, model_q[0]); end
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
    void'(model_q.pop_front());
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_single: got v=%b want 0", rd_valid); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h01, 1'b0, 1'b1);
    tick(2);
    n_checks++; if (parity_err !== 1'b1 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL parity_bad: got pe=%b v=%b want pe=1 v=0", parity_err, rd_valid); end
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    send_frame(8'h01, 1'b1, 1'b1);
    tick(2);
    n_checks++; if (parity_err !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 8'h01) begin n_fail++; $display("FAIL parity_good: got pe=%b v=%b d=%h want pe=0 v=1 d=01", parity_err, rd_valid, rd_data); end
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_push_pop_full();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
